// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: walks a combinational block through every input vector,
// captures its true/complement outputs and grades the result against EXPECTED.
module truth_table_sweeper #(
    parameter int                   N_IN        = 3,
    parameter int                   HOLD_CYCLES = 4,
    parameter logic [(2**N_IN)-1:0] EXPECTED    = 8'h3A
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   f_in,
    input  logic                   fn_in,
    output logic [N_IN-1:0]        vec_out,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [(2**N_IN)-1:0]   tt_out,
    output logic [N_IN:0]          mism_cnt,
    output logic                   comp_err
);

    localparam int NV = 2**N_IN;
    // The hold counter needs at least one bit even when every edge is a sample edge.
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [N_IN-1:0] VEC_LAST  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [N_IN-1:0]   r_vec;
    logic [N_IN-1:0]   w_vec_nxt;
    logic [HW-1:0]     r_hold;
    logic [HW-1:0]     w_hold_nxt;
    logic [NV-1:0]     r_tt;
    logic [NV-1:0]     w_tt_nxt;
    logic [N_IN:0]     r_mism;
    logic [N_IN:0]     w_mism_nxt;
    logic              r_cerr;
    logic              w_cerr_nxt;
    logic              r_pass;
    logic              w_pass_nxt;
    logic              w_mism_bit;
    logic              w_cerr_bit;

    assign w_mism_bit = (f_in != EXPECTED[r_vec]);
    assign w_cerr_bit = (fn_in == f_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_vec   <= '0;
            r_hold  <= '0;
            r_tt    <= '0;
            r_mism  <= '0;
            r_cerr  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_vec   <= w_vec_nxt;
            r_hold  <= w_hold_nxt;
            r_tt    <= w_tt_nxt;
            r_mism  <= w_mism_nxt;
            r_cerr  <= w_cerr_nxt;
            r_pass  <= w_pass_nxt;
        end
    end

    // Abort outranks both a start in IDLE and a coincident sample edge in APPLY.
    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        w_hold_nxt  = r_hold;
        w_tt_nxt    = r_tt;
        w_mism_nxt  = r_mism;
        w_cerr_nxt  = r_cerr;
        w_pass_nxt  = r_pass;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_state_nxt = S_APPLY;
                    w_vec_nxt   = '0;
                    w_hold_nxt  = '0;
                    w_tt_nxt    = '0;
                    w_mism_nxt  = '0;
                    w_cerr_nxt  = 1'b0;
                    w_pass_nxt  = 1'b0;
                end
            end
            S_APPLY: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_vec_nxt   = '0;
                    w_hold_nxt  = '0;
                    w_pass_nxt  = 1'b0;
                end else if (r_hold == HOLD_LAST) begin
                    w_hold_nxt      = '0;
                    w_tt_nxt[r_vec] = f_in;
                    w_mism_nxt      = r_mism + {{N_IN{1'b0}}, w_mism_bit};
                    w_cerr_nxt      = r_cerr | w_cerr_bit;
                    if (r_vec == VEC_LAST) begin
                        w_state_nxt = S_DONE;
                        w_pass_nxt  = (w_mism_nxt == '0) && !w_cerr_nxt;
                    end else begin
                        w_vec_nxt = r_vec + 1'b1;
                    end
                end else begin
                    w_hold_nxt = r_hold + 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign vec_out  = r_vec;
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign pass     = r_pass;
    assign tt_out   = r_tt;
    assign mism_cnt = r_mism;
    assign comp_err = r_cerr;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: a modelled logic block feeds f/fn,
// each sweep's predicted result is queued at start and compared at done.
module tb_truth_table_sweeper;

    localparam int N_IN  = 3;
    localparam int HOLD  = 4;
    localparam int NV    = 8;
    localparam int SWEEP = NV * HOLD;
    localparam logic [7:0] GOLD = 8'h3A;

    typedef struct {
        logic [7:0] tt;
        logic [3:0] mism;
        logic       cerr;
        logic       pass;
    } result_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] dutF    = GOLD;
    logic [7:0] tieMask = 8'h00;
    logic       f_in;
    logic       fn_in;
    logic [2:0] vec_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] tt_out;
    logic [3:0] mism_cnt;
    logic       comp_err;

    int checks = 0;
    int errors = 0;
    result_t sb[$];

    // Modelled logic block: F from a table, Fn normally ~F but tied to F where tieMask is set.
    assign f_in  = dutF[vec_out];
    assign fn_in = tieMask[vec_out] ? f_in : ~f_in;

    truth_table_sweeper #(
        .N_IN(N_IN),
        .HOLD_CYCLES(HOLD),
        .EXPECTED(GOLD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .f_in(f_in),
        .fn_in(fn_in),
        .vec_out(vec_out),
        .busy(busy),
        .done(done),
        .pass(pass),
        .tt_out(tt_out),
        .mism_cnt(mism_cnt),
        .comp_err(comp_err)
    );

    always #5 clk = ~clk;

    function automatic result_t predict();
        result_t r;
        int m = 0;
        r.tt   = dutF;
        r.cerr = |tieMask;
        for (int i = 0; i < NV; i++)
            if (dutF[i] != GOLD[i]) m++;
        r.mism = 4'(m);
        r.pass = (m == 0) && !r.cerr;
        return r;
    endfunction

    // Pulses start, queues the prediction, and returns cycles until done (-1 on timeout).
    task automatic startAndWait(output int latency);
        @(negedge clk);
        start = 1'b1;
        sb.push_back(predict());
        @(negedge clk);
        start = 1'b0;
        latency = -1;
        for (int n = 0; n <= SWEEP + 20; n++) begin
            if (done) begin
                latency = n;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({busy, done, pass, comp_err} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b want 0000", {busy, done, pass, comp_err});
        end
        checks++;
        if ({vec_out, tt_out, mism_cnt} !== 15'd0) begin
            errors++;
            $display("[TB] FAIL reset_data: vec=%0d tt=%h mism=%0d want all 0", vec_out, tt_out, mism_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_clean_sweep();
        result_t exp;
        int doneAt = -1;
        dutF = GOLD;
        tieMask = 8'h00;
        @(negedge clk);
        start = 1'b1;
        sb.push_back(predict());
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n <= SWEEP + 20; n++) begin
            if (n < SWEEP) begin
                checks++;
                if (vec_out !== 3'(n / HOLD) || busy !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL clean_vec n=%0d: vec=%0d busy=%b want vec=%0d busy=1", n, vec_out, busy, n / HOLD);
                end
            end
            if (done) begin
                doneAt = n;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (doneAt !== SWEEP) begin
            errors++;
            $display("[TB] FAIL clean_latency: got %0d want %0d", doneAt, SWEEP);
        end
        checks++;
        if (busy !== 1'b1 || vec_out !== 3'd7) begin
            errors++;
            $display("[TB] FAIL clean_done_state: busy=%b vec=%0d want busy=1 vec=7", busy, vec_out);
        end
        exp = sb.pop_front();
        checks++;
        if (tt_out !== exp.tt || mism_cnt !== exp.mism || comp_err !== exp.cerr || pass !== exp.pass) begin
            errors++;
            $display("[TB] FAIL clean_result: tt=%h mism=%0d cerr=%b pass=%b want tt=%h mism=%0d cerr=%b pass=%b",
                     tt_out, mism_cnt, comp_err, pass, exp.tt, exp.mism, exp.cerr, exp.pass);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || pass !== exp.pass || tt_out !== exp.tt) begin
            errors++;
            $display("[TB] FAIL clean_after_done: done=%b busy=%b pass=%b tt=%h want 0 0 %b %h",
                     done, busy, pass, tt_out, exp.pass, exp.tt);
        end
    endtask

    task automatic test_stuck_zero();
        result_t exp;
        int lat;
        dutF = 8'h00;
        tieMask = 8'h00;
        startAndWait(lat);
        exp = sb.pop_front();
        checks++;
        if (lat !== SWEEP) begin
            errors++;
            $display("[TB] FAIL stuck_latency: got %0d want %0d", lat, SWEEP);
        end
        checks++;
        if (tt_out !== exp.tt || mism_cnt !== exp.mism || comp_err !== exp.cerr || pass !== exp.pass) begin
            errors++;
            $display("[TB] FAIL stuck_result: tt=%h mism=%0d cerr=%b pass=%b want tt=%h mism=%0d cerr=%b pass=%b",
                     tt_out, mism_cnt, comp_err, pass, exp.tt, exp.mism, exp.cerr, exp.pass);
        end
    endtask

    task automatic test_comp_err();
        result_t exp;
        int lat;
        dutF = GOLD;
        tieMask = 8'h20;
        startAndWait(lat);
        exp = sb.pop_front();
        checks++;
        if (lat !== SWEEP) begin
            errors++;
            $display("[TB] FAIL comperr_latency: got %0d want %0d", lat, SWEEP);
        end
        checks++;
        if (tt_out !== exp.tt || mism_cnt !== exp.mism || comp_err !== exp.cerr || pass !== exp.pass) begin
            errors++;
            $display("[TB] FAIL comperr_result: tt=%h mism=%0d cerr=%b pass=%b want tt=%h mism=%0d cerr=%b pass=%b",
                     tt_out, mism_cnt, comp_err, pass, exp.tt, exp.mism, exp.cerr, exp.pass);
        end
        tieMask = 8'h00;
    endtask

    // Abort lands on vector 3's sample edge, so only vectors 0..2 may be captured.
    task automatic test_abort();
        int dones = 0;
        dutF = GOLD;
        tieMask = 8'h00;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 15; n++) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || vec_out !== 3'd0 || pass !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_state: busy=%b done=%b vec=%0d pass=%b want 0 0 0 0", busy, done, vec_out, pass);
        end
        checks++;
        if (tt_out !== (GOLD & 8'h07) || mism_cnt !== 4'd0) begin
            errors++;
            $display("[TB] FAIL abort_partial: tt=%h mism=%0d want tt=%h mism=0", tt_out, mism_cnt, GOLD & 8'h07);
        end
        for (int n = 0; n < SWEEP + 8; n++) begin
            if (done) dones++;
            @(negedge clk);
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("[TB] FAIL abort_no_done: saw %0d done pulses want 0", dones);
        end
    endtask

    task automatic test_start_abort_idle();
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || tt_out !== (GOLD & 8'h07)) begin
            errors++;
            $display("[TB] FAIL idle_abort_wins: busy=%b tt=%h want busy=0 tt=%h", busy, tt_out, GOLD & 8'h07);
        end
    endtask

    task automatic test_back_to_back();
        result_t exp;
        int doneAt = -1;
        int dones = 0;
        dutF = GOLD;
        tieMask = 8'h00;
        @(negedge clk);
        start = 1'b1;
        sb.push_back(predict());
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n <= SWEEP + 12; n++) begin
            start = (n == 8);
            if (done) begin
                dones++;
                if (doneAt < 0) doneAt = n;
                if (dones == 1) begin
                    exp = sb.pop_front();
                    checks++;
                    if (tt_out !== exp.tt || mism_cnt !== exp.mism || pass !== exp.pass) begin
                        errors++;
                        $display("[TB] FAIL restart_result: tt=%h mism=%0d pass=%b want tt=%h mism=%0d pass=%b",
                                 tt_out, mism_cnt, pass, exp.tt, exp.mism, exp.pass);
                    end
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (doneAt !== SWEEP || dones !== 1) begin
            errors++;
            $display("[TB] FAIL restart_ignored: first done at %0d count %0d want %0d and 1", doneAt, dones, SWEEP);
        end
    endtask

    task automatic test_reset_midsweep();
        int lat;
        int dones = 0;
        result_t exp;
        dutF = GOLD;
        tieMask = 8'h00;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 26; n++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, pass, comp_err} !== 4'b0000 || {vec_out, tt_out, mism_cnt} !== 15'd0) begin
            errors++;
            $display("[TB] FAIL midsweep_reset: busy=%b done=%b pass=%b cerr=%b vec=%0d tt=%h mism=%0d want all 0",
                     busy, done, pass, comp_err, vec_out, tt_out, mism_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            if (done || busy) dones++;
            @(negedge clk);
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("[TB] FAIL midsweep_quiet: %0d busy/done cycles after reset want 0", dones);
        end
        startAndWait(lat);
        exp = sb.pop_front();
        checks++;
        if (lat !== SWEEP || tt_out !== exp.tt || mism_cnt !== exp.mism || pass !== exp.pass) begin
            errors++;
            $display("[TB] FAIL midsweep_rerun: lat=%0d tt=%h mism=%0d pass=%b want %0d %h %0d %b",
                     lat, tt_out, mism_cnt, pass, SWEEP, exp.tt, exp.mism, exp.pass);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_clean_sweep();
        test_stuck_zero();
        test_comp_err();
        test_abort();
        test_start_abort_idle();
        test_back_to_back();
        test_reset_midsweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
